// File: rtl/regbus_pkg.sv
// Shared definitions for the peripheral register bus: default widths,
// the arbiter FSM encoding and well-known register addresses.
package regbus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] GPIO_OUT_ADDR = 8'h00;

endpackage

// File: rtl/regbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit after ptr,
// wrapping modulo N. Returns a one-hot grant and the binary winner index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // ptr itself is searched last, so the previous winner has lowest priority
    for (int off = 1; off <= N; off++) begin
      int j;
      j = (int'(ptr) + off) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing the single-port register bus between NUM_REQ
// requesters; one transaction per three cycles (grant, access, response).
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic                      bus_we,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic               we_reg;
  logic [DATA_W-1:0]  rdata_reg;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = pick_grant;
          state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
      RESP: begin
        rsp_valid  = NUM_REQ'(1) << idx_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A grant offered while reset is held would never be captured
    if (reset) req_ready = '0;
  end

  // Gated with reset so a write caught by reset in ACCESS never reaches decode
  assign bus_we    = (state_reg == ACCESS) && !reset && we_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign rsp_rdata = rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
      idx_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && |req_valid) begin
        ptr_reg   <= pick_idx;
        idx_reg   <= pick_idx;
        addr_reg  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        wdata_reg <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        we_reg    <= req_we[pick_idx];
      end
      if (state_reg == ACCESS) rdata_reg <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter with a one-register GPIO decode model.
module tb_regbus_arbiter;
  import regbus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, bus_wdata, bus_rdata;
  logic [AW-1:0]   bus_addr;
  logic            bus_we;
  logic [DW-1:0]   gpio;

  int tests_run = 0;
  int failures  = 0;

  regbus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  // Register decode: GPIO_OUT at address 0, everything else reads 0
  always_ff @(posedge clk) begin
    if (reset) gpio <= '0;
    else if (bus_we && bus_addr == GPIO_OUT_ADDR) gpio <= bus_wdata;
  end
  assign bus_rdata = (bus_addr == GPIO_OUT_ADDR) ? gpio : '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic do_txn(input int i, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    int n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(1) << i);
    check_eq({tag, "_we_idle"}, 32'(bus_we), 32'd0);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_bus_we"}, 32'(bus_we), 32'(we));
    check_eq({tag, "_bus_addr"}, 32'(bus_addr), 32'(a));
    check_eq({tag, "_bus_wdata"}, bus_wdata, d);
    check_eq({tag, "_rsp_early"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1) << i);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
    check_eq({tag, "_we_resp"}, 32'(bus_we), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int we_cyc[$];
    logic [31:0] wseq[$];
    int bad, seen0;

    reset = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_bus_addr", 32'(bus_addr), 32'd0);
    check_eq("rst_bus_we", 32'(bus_we), 32'd0);

    // Single write then read-back through another requester
    do_txn(0, 1'b1, 8'h00, 32'h0000_00A5, 32'h0000_0000, "wr0");
    do_txn(1, 1'b0, 8'h00, 32'h0000_0000, 32'h0000_00A5, "rd1");

    // Round-robin resume after req2: req3 must beat req1
    do_txn(2, 1'b0, 8'h00, 32'h0, 32'h0000_00A5, "rd2");
    @(posedge clk); #1;
    req_we = '0; req_addr = '0;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    @(negedge clk);
    check_eq("rr_first", 32'(req_ready), 32'h8);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rr_rsp3", 32'(rsp_valid), 32'h8);
    @(negedge clk);
    check_eq("rr_second", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rr_rsp1", 32'(rsp_valid), 32'h2);

    // Unmapped read
    do_txn(2, 1'b0, 8'h04, 32'h0, 32'h0, "unmapped");

    // req1 pulses valid while req0 owns the bus
    @(posedge clk); #1;
    req_addr = '0; req_we = '0;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("drop_ready0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b1;
    bad = 0; seen0 = 0;
    @(negedge clk);
    if (req_ready[1] || rsp_valid[1]) bad++;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (req_ready[1] || rsp_valid[1]) bad++;
      if (rsp_valid[0]) seen0++;
    end
    check_eq("drop_req1_served", 32'(bad), 32'd0);
    check_eq("drop_rsp0_count", 32'(seen0), 32'd1);

    // All four requesters continuously valid from reset
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_we[i] = 1'b1;
      req_addr[i*AW +: AW] = 8'h00;
      req_wdata[i*DW +: DW] = 32'h10 + 32'(i);
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
      if (bus_we) begin
        we_cyc.push_back(c);
        wseq.push_back(bus_wdata);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    check_eq("all_grant_count", 32'(grants.size()), 32'd5);
    check_eq("all_we_count", 32'(we_cyc.size()), 32'd5);
    if (grants.size() >= 5)
      for (int k = 0; k < 5; k++) check_eq($sformatf("all_grant%0d", k), 32'(grants[k]), 32'(k % N));
    if (we_cyc.size() >= 5)
      for (int k = 0; k < 4; k++) check_eq($sformatf("all_we_gap%0d", k), 32'(we_cyc[k+1] - we_cyc[k]), 32'd3);
    if (wseq.size() >= 4)
      for (int k = 0; k < 4; k++) check_eq($sformatf("all_gpio%0d", k), wseq[k], 32'h10 + 32'(k));
    @(negedge clk);
    check_eq("all_gpio_final", gpio, 32'h10);

    // Reset caught during the ACCESS of a write of FF
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_addr[0 +: AW] = 8'h00; req_wdata[0 +: DW] = 32'hFF;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("rstacc_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_eq("rstacc_we_blocked", 32'(bus_we), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rstacc_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rstacc_bus_we", 32'(bus_we), 32'd0);
    check_eq("rstacc_bus_wdata", bus_wdata, 32'd0);
    check_eq("rstacc_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    check_eq("rstacc_no_late_rsp", 32'(rsp_valid), 32'd0);
    do_txn(1, 1'b0, 8'h00, 32'h0, 32'h0, "rstacc_gpio");

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
Round-robin arbiter that shares the single-port peripheral register bus (addr/wdata/we/rdata, GPIO register block and peers) between NUM_REQ requesters, e.g. host interface, debug port and sequencer.
- Each requester issues one read or write transaction at a time with a valid/ready handshake.
- Each requester gets a one-cycle response pulse.
- Sits between the requesters and the register decode; it is the only driver of the register bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester transaction request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DATA_W  read data, shared; valid when any rsp_valid bit is 1
- bus_addr  out  ADDR_W  register bus address
- bus_wdata  out  DATA_W  register bus write data
- bus_we  out  1  register bus write strobe
- bus_rdata  in  DATA_W  combinational read data from register decode

Behaviour:
- Reset values:
  - state = IDLE
  - ptr = NUM_REQ-1, so requester 0 has top priority after reset
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0
  - bus_addr = 0, bus_wdata = 0, bus_we = 0
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, winner = first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in this cycle only.
  - At the clock edge: capture the winner's addr/wdata/we and its index, set ptr <= winner, go to ACCESS.
  - If no req_valid is set, stay in IDLE and leave ptr unchanged.
- ACCESS (exactly one cycle):
  - bus_addr and bus_wdata are driven from the captured registers.
  - bus_we = captured we.
  - rsp_rdata <= bus_rdata at the end of the cycle, on both reads and writes.
- RESP (one cycle):
  - rsp_valid[granted index] = 1; rsp_rdata holds the sampled value.
  - Next state is IDLE.
- Handshake:
  - A requester holds valid, we, addr and wdata stable until it sees ready.
  - The arbiter samples inputs only in the cycle ready is high.
  - Dropping valid before ready is legal; that requester is not served.
  - A requester may reassert valid in the same cycle its rsp_valid is high; it competes in the following IDLE cycle.
- Throughput: one transaction per 3 cycles. Latency is ready at cycle T, bus_we at T+1, rsp_valid at T+2.
- bus_we is 0 in every cycle outside ACCESS. bus_addr and bus_wdata hold their last values when idle.
- rsp_rdata holds until the next ACCESS completes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 other grants.
- Reset mid-operation: in any state, return to IDLE with all outputs at reset values next cycle.
  - A pending transaction is dropped: no rsp_valid, and no bus_we if reset is asserted during ACCESS.
- Out-of-range or unmapped addresses are passed through unchanged. Decode returns 0, and the response is still given.

Decomposition:
- Shared package regbus_pkg:
  - ADDR_W and DATA_W defaults
  - FSM state enum (IDLE, ACCESS, RESP)
  - GPIO_OUT_ADDR = 8'h00
- One natural sub-module, rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: request vector and ptr. Outputs: one-hot grant and winner index.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single write: req0 write addr 8'h00 wdata 32'h0000_00A5.
  - ready0 at T, bus_we=1 at T+1 with bus_addr 00 and bus_wdata A5, rsp_valid0 at T+2.
  - A follow-up read by req1 returns rsp_rdata 32'h0000_00A5.
- All four requesters valid continuously from reset with writes, data 8'h10+i:
  - Grant order is 0,1,2,3,0.
  - Consecutive bus_we pulses are 3 cycles apart.
  - GPIO sequence is 10,11,12,13.
- Round-robin resume: req2 served, then req1 and req3 both valid -> req3 granted first, then req1.
- Read of unmapped addr 8'h04 by req2 -> rsp_valid2 with rsp_rdata 32'h0, and bus_we stays 0 throughout.
- Valid dropped: req1 asserts valid for 1 cycle while req0 occupies the bus -> req1 is never readied and no rsp_valid1 is produced.
- Reset asserted during ACCESS of a write of 8'hFF:
  - Next cycle: state IDLE, bus_we=0, no rsp_valid.
  - GPIO reads back 8'h00 after reset.
